// File: rtl/shift_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_pkg : mode encoding and one-step shift function for univ_shift_reg
// Rev 1.0
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  // Operands are zero-extended to MAX_W; width selects the live MSB position.
  function automatic word_t next_q(input word_t    q,
                                   input logic [2:0] mode,
                                   input logic     serial_in,
                                   input word_t    parallel_in,
                                   input int       width);
    word_t mask;
    word_t msb;
    word_t r;
    logic  top;
    mask = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
    msb  = word_t'(1) << (width - 1);
    top  = |(q & msb);
    case (mode)
      MODE_HOLD: r = q;
      MODE_LOAD: r = parallel_in;
      MODE_SHL:  r = (q << 1) | word_t'(serial_in);
      MODE_SHR:  r = (q >> 1) | (serial_in ? msb : '0);
      MODE_ROL:  r = (q << 1) | word_t'(top);
      MODE_ROR:  r = (q >> 1) | (q[0] ? msb : '0);
      MODE_ASR:  r = (q >> 1) | (top ? msb : '0);
      default:   r = '0;
    endcase
    return r & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_seq_ctrl : start/count sequencer producing per-edge step enables
// Rev 1.0
// ---------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             step_en,
  output logic [2:0]       eff_mode,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_l_q, mode_l_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_l_d = mode_l_q;
    done_d   = 1'b0;
    step_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        step_en = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        // A zero-length request completes immediately without touching q.
        if (start) begin
          if (count != '0) begin
            state_d  = ST_RUN;
            cnt_d    = count;
            mode_l_d = mode;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          step_en = en;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_l_q <= MODE_HOLD;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_l_q <= mode_l_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign eff_mode = busy ? mode_l_q : mode;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// univ_shift_reg : WIDTH-bit universal shift register with auto-sequencing
// Rev 1.0
// ---------------------------------------------------------------------------
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             step_en;
  logic [2:0]       eff_mode;
  word_t            next_word;

  shift_seq_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .start    (start),
    .count    (count),
    .step_en  (step_en),
    .eff_mode (eff_mode),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    next_word = next_q(word_t'(q_q), eff_mode, serial_in, word_t'(parallel_in), WIDTH);
    q_d       = q_q;
    if (step_en) begin
      q_d = next_word[WIDTH-1:0];
    end
  end

  generate
    if (WIDTH < MAX_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^next_word[MAX_W-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign parallel_out = q_q;
  assign serial_out   = ((eff_mode == MODE_SHL) || (eff_mode == MODE_ROL)) ? q_q[WIDTH-1] : q_q[0];

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// tb_univ_shift_reg : directed pins plus randomized run against an arithmetic model.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  parallel_in = '0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  parallel_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .start        (start),
    .count        (count),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference: one step expressed as integer arithmetic on an 8-bit value.
  function automatic int ref_step(int q, int m, int sin, int pin);
    case (m)
      0: return q;
      1: return pin;
      2: return (q * 2) % 256 + sin;
      3: return q / 2 + sin * 128;
      4: return (q * 2) % 256 + q / 128;
      5: return q / 2 + (q % 2) * 128;
      6: return q / 2 + (q / 128) * 128;
      default: return 0;
    endcase
  endfunction

  int m_q = 0, m_rem = 0, m_mode = 0;
  bit m_busy = 0, m_done = 0, m_valid = 0;

  always @(posedge clk) begin : model
    int nq, nrem, nmode;
    bit nbusy, ndone;
    nq = m_q; nrem = m_rem; nmode = m_mode; nbusy = m_busy; ndone = 0;
    if (rst) begin
      nq = 0; nrem = 0; nmode = 0; nbusy = 0;
    end else if (m_busy) begin
      nq = ref_step(m_q, m_mode, int'(serial_in), int'(parallel_in));
      nrem = m_rem - 1;
      nbusy = (nrem != 0);
      ndone = (nrem == 0);
    end else if (start) begin
      if (count == 0) ndone = 1;
      else begin
        nbusy = 1; nrem = int'(count); nmode = int'(mode);
      end
    end else if (en) begin
      nq = ref_step(m_q, int'(mode), int'(serial_in), int'(parallel_in));
    end
    m_q <= nq; m_rem <= nrem; m_mode <= nmode; m_busy <= nbusy; m_done <= ndone;
    if (rst) m_valid <= 1;
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      int em, eso;
      em  = m_busy ? m_mode : int'(mode);
      eso = (em == 2 || em == 4) ? (m_q / 128) : (m_q % 2);
      check("q", int'(parallel_out), m_q);
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("serial_out", int'(serial_out), eso);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(logic [W-1:0] v);
    en = 1; mode = 3'd1; parallel_in = v; start = 0;
    tick();
    en = 0; mode = 3'd0;
  endtask

  initial begin
    logic [2:0] step_mode [6];
    logic       step_sin  [6];
    logic [7:0] step_exp  [6];
    step_mode = '{3'd2, 3'd3, 3'd6, 3'd5, 3'd4, 3'd7};
    step_sin  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step_exp  = '{8'h4B, 8'h52, 8'hD2, 8'hD2, 8'h4B, 8'h00};

    rst = 1; tick(); tick();
    check("rst_q", int'(parallel_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 0;
    load(8'hA5);
    check("load", int'(parallel_out), 8'hA5);

    for (int i = 0; i < 6; i++) begin
      load(8'hA5);
      en = 1; mode = step_mode[i]; serial_in = step_sin[i];
      #1;
      if (i == 0) check("shl_serial_out", int'(serial_out), 1);
      tick();
      check("single_step", int'(parallel_out), int'(step_exp[i]));
      en = 0; serial_in = 0;
    end

    // ROL x3 from 0x81, with start/en/mode noise while busy
    load(8'h81);
    start = 1; mode = 3'd4; count = 4'd3; tick();
    check("seq_busy0", int'(busy), 1);
    check("seq_q0", int'(parallel_out), 8'h81);
    en = 1; mode = 3'd7; count = 4'd9; tick();
    check("seq_q1", int'(parallel_out), 8'h03);
    tick();
    check("seq_q2", int'(parallel_out), 8'h06);
    start = 0; en = 0; mode = 3'd0; tick();
    check("seq_q3", int'(parallel_out), 8'h0C);
    check("seq_done", int'(done), 1);
    check("seq_busy_end", int'(busy), 0);
    tick();
    check("seq_done_low", int'(done), 0);

    // count = 0
    load(8'h3C);
    start = 1; count = 0; tick(); start = 0;
    check("cnt0_done", int'(done), 1);
    check("cnt0_busy", int'(busy), 0);
    check("cnt0_q", int'(parallel_out), 8'h3C);

    // reset mid-sequence
    load(8'hFF);
    start = 1; mode = 3'd3; serial_in = 0; count = 4'd5; tick(); start = 0;
    tick(); tick();
    check("mid_q2", int'(parallel_out), 8'h3F);
    rst = 1; tick(); rst = 0;
    check("abort_q", int'(parallel_out), 0);
    check("abort_busy", int'(busy), 0);
    tick();
    check("abort_no_done", int'(done), 0);
    load(8'h01);
    start = 1; mode = 3'd4; count = 4'd1; tick(); start = 0; tick();
    check("restart_q", int'(parallel_out), 8'h02);
    check("restart_done", int'(done), 1);

    // back-to-back ROR x1 twice
    load(8'h01);
    start = 1; mode = 3'd5; count = 4'd1; tick(); tick();
    check("b2b_q1", int'(parallel_out), 8'h80);
    check("b2b_done1", int'(done), 1);
    tick(); start = 0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_gap", int'(done), 0);
    tick();
    check("b2b_q2", int'(parallel_out), 8'h40);
    check("b2b_done2", int'(done), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      en          = $urandom_range(0, 1);
      mode        = 3'($urandom_range(0, 7));
      serial_in   = $urandom_range(0, 1);
      parallel_in = 8'($urandom);
      start       = ($urandom_range(0, 5) == 0);
      count       = 4'($urandom_range(0, 10));
      tick();
    end
    rst = 0; start = 0; en = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
